// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Multi-cycle load/store engine between the EX stage and a simple
//   request/acknowledge memory bus. A one-cycle start captures the access,
//   the unit drives a word-aligned bus request with byte enables and
//   lane-replicated store data, waits for mem_ack (bounded by TIMEOUT_CYCLES)
//   and returns a one-cycle done pulse with the extended load result.
//
// Parameter
//   TIMEOUT_CYCLES : max REQ cycles without mem_ack before the access errors.
//
// Optional feature (compile-time macro)
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned LH/LHU/SH/LW/SW complete
//                          immediately with err=1, misalign=1 and no bus access.
//                          When undefined, low address bits are simply ignored
//                          and misalign is tied low.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   start, is_store,
//   funct_3, addr, wdata  : access request from EX (sampled when idle)
//   busy                  : pipeline stall, high while an access is in flight
//   done, err, misalign   : completion pulse and its qualifiers
//   rdata                 : extended load data (0 for stores and errors)
//   mem_req, mem_we,
//   mem_addr, mem_be,
//   mem_wdata             : bus request side
//   mem_ack, mem_rdata    : bus response side
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct_3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last count value at which a further ack-less REQ cycle means timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_is_store;
  logic [2:0]        r_f3;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              w_legal;
  logic              w_misalign;

  // Legal encodings: byte/half/word for both, unsigned byte/half for loads only.
  function automatic logic f_legal(input logic st, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~st;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables; funct_3[1:0] encodes the access size for every legal type.
  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so the bus slave can pick any lane.
  function automatic logic [31:0] f_wrep(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{wd[7:0]}};
      2'b01:   w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    case (sz)
      2'b01:   m = a[0];
      2'b10:   m = a[1] | a[0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  logic r_misalign;

  assign w_misalign = w_legal & f_misaligned(funct_3[1:0], addr[1:0]);
  assign misalign   = (r_state == S_ERR) & r_misalign;

  // Remember whether the pending error was caused by misalignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_misalign <= w_misalign;
    end else begin
      r_misalign <= r_misalign;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign misalign   = 1'b0;
`endif

  assign w_legal = f_legal(is_store, funct_3);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an ack in the final allowed cycle wins over the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!w_legal || w_misalign) begin
            w_next_state = S_ERR;
          end else begin
            w_next_state = S_REQ;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_next_state = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = S_ERR;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ERR:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Capture the access attributes; they stay frozen for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_store <= 1'b0;
      r_f3       <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else if (r_state == S_IDLE && start) begin
      r_is_store <= is_store;
      r_f3       <= funct_3;
      r_addr     <= addr;
      r_wdata    <= wdata;
    end else begin
      r_is_store <= r_is_store;
      r_f3       <= r_f3;
      r_addr     <= r_addr;
      r_wdata    <= r_wdata;
    end
  end

  // Wait counter: held at zero outside REQ so every REQ entry starts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != S_REQ) begin
      r_cnt <= '0;
    end else if (!mem_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Result register: loaded on the way into DONE/ERR, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
    end else if (r_state == S_REQ && mem_ack) begin
      r_rdata <= r_is_store ? 32'd0 : f_extract(r_f3, r_addr[1:0], mem_rdata);
    end else if (w_next_state == S_ERR) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) | (r_state == S_ERR);
  assign err       = (r_state == S_ERR);
  assign rdata     = r_rdata;
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = (r_state == S_REQ) & r_is_store;
  assign mem_be    = (r_state == S_REQ) ? f_be(r_f3[1:0], r_addr[1:0]) : 4'b0000;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = f_wrep(r_f3[1:0], r_wdata);

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit. Two instances share the stimulus:
//   u_dut (TIMEOUT_CYCLES=4) is used for most scenarios, u_long (default
//   timeout) for the long-wait scenario. Expected values come from a
//   size/offset arithmetic model of the access rules.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct_3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        m_busy, m_done, m_err, m_misalign, m_mem_req, m_mem_we;
  logic [31:0] m_rdata, m_mem_addr, m_mem_wdata;
  logic [3:0]  m_mem_be;
  logic        l_busy, l_done, l_err, l_misalign, l_mem_req, l_mem_we;
  logic [31:0] l_rdata, l_mem_addr, l_mem_wdata;
  logic [3:0]  l_mem_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct_3(funct_3), .addr(addr), .wdata(wdata),
    .busy(m_busy), .done(m_done), .err(m_err), .rdata(m_rdata),
    .misalign(m_misalign), .mem_req(m_mem_req), .mem_we(m_mem_we),
    .mem_addr(m_mem_addr), .mem_be(m_mem_be), .mem_wdata(m_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  load_store_unit u_long (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct_3(funct_3), .addr(addr), .wdata(wdata),
    .busy(l_busy), .done(l_done), .err(l_err), .rdata(l_rdata),
    .misalign(l_misalign), .mem_req(l_mem_req), .mem_we(l_mem_we),
    .mem_addr(l_mem_addr), .mem_be(l_mem_be), .mem_wdata(l_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One access: dly = number of ack-less REQ cycles before ack (large = never);
  // restart_cyc = cycle at which a spurious second start is pulsed (0 = none).
  task automatic run_op(input string name, input bit use_long, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly,
                        input logic [31:0] rd, input int restart_cyc);
    int          tmo, size, off, edone, ereq, dcyc, reqn, bad, busybad;
    logic        legal, emis, eerr, got_done, o_err, o_mis;
    logic [3:0]  ebe, o_be;
    logic [31:0] ewd, erd, eaddr, v, m, o_rdata;
    logic        o_busy, o_done, o_req, o_we;
    logic [31:0] o_addr, o_wd;

    // reference model
    tmo   = use_long ? 255 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                 f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    off   = int'(a[1:0]);
    off   = off - (off % size);
    ebe   = 4'(((1 << size) - 1) << off);
    eaddr = a & 32'hFFFF_FFFC;
    if (size == 1)      ewd = {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (size == 2) ewd = {16'd0, wd[15:0]} * 32'h0001_0001;
    else                ewd = wd;
    m = (size == 1) ? 32'h0000_00FF : (size == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    v = (rd >> (8 * off)) & m;
    if (!f3[2] && size < 4 && ((v & ((m >> 1) + 32'd1)) != 32'd0)) v = v | ~m;
`ifdef LSU_MISALIGN_TRAP_EN
    emis = legal && ((int'(a[1:0]) % size) != 0);
`else
    emis = 1'b0;
`endif
    if (!legal || emis) begin
      edone = 1; ereq = 0; eerr = 1'b1; erd = 32'd0;
    end else if (dly >= tmo) begin
      edone = tmo + 1; ereq = tmo; eerr = 1'b1; erd = 32'd0;
    end else begin
      edone = dly + 2; ereq = dly + 1; eerr = 1'b0; erd = st ? 32'd0 : v;
    end

    // drive and observe
    @(negedge clk);
    is_store = st; funct_3 = f3; addr = a; wdata = wd; start = 1'b1; mem_ack = 1'b0;
    got_done = 1'b0; dcyc = 0; reqn = 0; bad = 0; busybad = 0;
    o_err = 1'b0; o_mis = 1'b0; o_rdata = 32'd0;
    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      o_busy = use_long ? l_busy    : m_busy;
      o_done = use_long ? l_done    : m_done;
      o_req  = use_long ? l_mem_req : m_mem_req;
      o_we   = use_long ? l_mem_we  : m_mem_we;
      o_be   = use_long ? l_mem_be  : m_mem_be;
      o_addr = use_long ? l_mem_addr  : m_mem_addr;
      o_wd   = use_long ? l_mem_wdata : m_mem_wdata;
      if (!o_busy) busybad++;
      if (o_done) begin
        got_done = 1'b1;
        dcyc     = cyc;
        o_err    = use_long ? l_err      : m_err;
        o_mis    = use_long ? l_misalign : m_misalign;
        o_rdata  = use_long ? l_rdata    : m_rdata;
      end else begin
        if (cyc == restart_cyc) begin
          start = 1'b1; is_store = ~st; funct_3 = 3'b000; addr = ~a; wdata = ~wd;
        end
        if (o_req) begin
          reqn++;
          if (o_addr !== eaddr || o_be !== ebe || o_we !== st || (st && o_wd !== ewd)) bad++;
          if (reqn == dly + 1) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
          end
        end
      end
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    if (!got_done) begin
      chk({name, "_done_seen"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_done_cyc"}, 32'(dcyc), 32'(edone));
      chk({name, "_req_cycles"}, 32'(reqn), 32'(ereq));
      chk({name, "_bus_attr"}, 32'(bad), 32'd0);
      chk({name, "_busy"}, 32'(busybad), 32'd0);
      chk({name, "_err"}, 32'(o_err), 32'(eerr));
      chk({name, "_misalign"}, 32'(o_mis), 32'(emis));
      chk({name, "_rdata"}, o_rdata, erd);
      // one cycle later: pulse over, unit idle, result held
      @(negedge clk);
      chk({name, "_done_after"}, 32'(use_long ? l_done : m_done), 32'd0);
      chk({name, "_busy_after"}, 32'(use_long ? l_busy : m_busy), 32'd0);
      chk({name, "_rdata_hold"}, use_long ? l_rdata : m_rdata, erd);
    end
  endtask

  initial begin
    int ndone;
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct_3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_mem_req", 32'(m_mem_req), 32'd0);
    chk("rst_mem_be", 32'(m_mem_be), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // long wait on the default-timeout instance with a mid-wait second start
    run_op("lw_wait5", 1'b1, 1'b0, 3'b010, 32'h0000_5008, 32'd0, 5, 32'hCAFE_F00D, 3);
    do_reset();

    run_op("sb_1003", 1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 32'd0, 0);
    run_op("lb_2001", 1'b0, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 0, 32'h0000_F000, 0);
    run_op("lbu_2001", 1'b0, 1'b0, 3'b100, 32'h0000_2001, 32'd0, 1, 32'h0000_F000, 0);
    run_op("lhu_2002", 1'b0, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 32'h8001_0000, 0);
    run_op("lw_tmo", 1'b0, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 1000, 32'd0, 0);
    run_op("lw_ack_last", 1'b0, 1'b0, 3'b010, 32'h0000_6004, 32'd0, 3, 32'h1234_5678, 0);
    run_op("ld_illegal", 1'b0, 1'b0, 3'b011, 32'h0000_7000, 32'd0, 0, 32'd0, 0);
    run_op("st_illegal", 1'b0, 1'b1, 3'b100, 32'h0000_7000, 32'h55, 0, 32'd0, 0);
    run_op("lw_3002", 1'b0, 1'b0, 3'b010, 32'h0000_3002, 32'd0, 0, 32'h89AB_CDEF, 0);
    run_op("sh_odd", 1'b0, 1'b1, 3'b001, 32'h0000_3003, 32'h0000_BEEF, 1, 32'd0, 0);
    do_reset();

    // reset during REQ: bus request drops at once, later ack is ignored
    @(negedge clk);
    is_store = 1'b0; funct_3 = 3'b010; addr = 32'h0000_4000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_req_before", 32'(m_mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_req_mem_req", 32'(m_mem_req), 32'd0);
    chk("rst_req_busy", 32'(m_busy), 32'd0);
    chk("rst_req_be", 32'(m_mem_be), 32'd0);
    chk("rst_req_we", 32'(m_mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (m_done) ndone++;
    end
    chk("rst_late_ack_done", 32'(ndone), 32'd0);
    chk("rst_late_ack_rdata", m_rdata, 32'd0);

    for (int i = 0; i < 60; i++) begin
      run_op("rand", 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, int'($urandom_range(0, 5)), $urandom,
             int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles to wait for mem_ack before abandoning an access.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request from EX to begin a load/store.
REQ-005 is_store  input  1  1 = store (OP_ST), 0 = load (OP_LD).
REQ-006 funct_3  input  3  access type: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-007 addr  input  32  byte address computed by the ALU (rs1+imm).
REQ-008 wdata  input  32  rs2 store data.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle done is high (inclusive); used as pipeline stall.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  qualified by done; 1 = illegal funct_3, timeout or misalignment.
REQ-012 rdata  output  32  extended load result for rd; valid while done=1.
REQ-013 misalign  output  1  qualified by done; misalignment cause flag.
REQ-014 mem_req / mem_we  output  1 each  bus request and write enable.
REQ-015 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-016 mem_be  output  4  byte enables.  mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_ack  input  1  bus completion.  mem_rdata  input  32  read word, valid with mem_ack.

Function
REQ-018 FSM states: IDLE, REQ, DONE, ERR.
REQ-019 IDLE: start=1 captures is_store, funct_3, addr, wdata; go to REQ if legal, else ERR; start while not IDLE is ignored.
REQ-020 REQ: mem_req=1, mem_addr/mem_be/mem_we/mem_wdata held constant until mem_ack.
REQ-021 REQ with mem_ack=1: load captures mem_rdata; go to DONE; mem_req drops the next cycle.
REQ-022 DONE: done=1, err=0, rdata valid for one cycle; return to IDLE.
REQ-023 ERR: done=1, err=1, rdata=0, no bus access issued; return to IDLE.
REQ-024 Latency: start at cycle 0, mem_req from cycle 1; ack at cycle k gives done at cycle k+1; zero-wait ack gives done at cycle 2.
REQ-025 A timeout counter clears on REQ entry and increments each REQ cycle without ack; on reaching TIMEOUT_CYCLES go to ERR; ack in the same cycle takes precedence.
REQ-026 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; SW be=4'b1111.
REQ-027 Loads: mem_be follows the same lane rule, mem_we=0.
REQ-028 Load extraction: byte=mem_rdata[8*addr[1:0]+:8], half=mem_rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-029 Stores: rdata=0 at done.
REQ-030 Illegal funct_3 = loads 011/110/111, stores 011-111.
REQ-031 Outside DONE/ERR: done, err, misalign are 0 and rdata holds its last value.

Reset
REQ-032 Reset asserted in any state forces IDLE, mem_req=0, mem_we=0, mem_be=0, done=0, err=0, misalign=0, busy=0, rdata=0, timeout counter=0, immediately; an in-flight access is abandoned and a late mem_ack is ignored.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go to ERR with misalign=1 and no bus access.
REQ-034 Macro undefined: no check; misalign is tied 0; halfword uses addr[1] only, word ignores addr[1:0]; the access proceeds normally.

Verification
REQ-035 SB addr=0x1003 wdata=0x000000AB, ack zero-wait -> mem_addr=0x1000, be=1000, mem_wdata=0xABABABAB, done at cycle 2, err=0.
REQ-036 LB addr=0x2001, mem_rdata=0x0000F000 -> rdata=0xFFFFFFF0; LBU same -> 0x000000F0; LHU addr=0x2002, mem_rdata=0x8001_0000 -> 0x00008001.
REQ-037 LW with ack after 5 wait cycles, start pulsed again mid-wait -> second start ignored, single done, busy high throughout.
REQ-038 LW with no ack, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then done=1 err=1 rdata=0.
REQ-039 Reset asserted while in REQ -> mem_req low same cycle; ack arriving after release produces no done.
REQ-040 LW addr=0x3002: with LSU_MISALIGN_TRAP_EN -> no mem_req, done/err/misalign=1 at cycle 1; without -> mem_addr=0x3000, be=1111, normal completion.
